// File: rtl/testdrive_apb_arbiter_pkg.sv
// rtl/testdrive_apb_arbiter_pkg.sv - shared state type and APB widths for the arbiter
package testdrive_apb_arbiter_pkg;

  localparam int APB_DATA_W = 32;
  localparam int APB_STRB_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } apb_state_t;

  // Width of a port index; never below one bit so single-bit vectors stay legal.
  function automatic int idx_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/testdrive_apb_arbiter_rr_arbiter.sv
// rtl/testdrive_apb_arbiter_rr_arbiter.sv - combinational round-robin pick starting at ptr
module testdrive_rr_arbiter
  import testdrive_apb_arbiter_pkg::*;
#(
  parameter int C_PORTS = 4,
  parameter int IW      = idx_bits(C_PORTS)
) (
  input  logic [C_PORTS-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [C_PORTS-1:0] grant,
  output logic [IW-1:0]      grant_idx,
  output logic               hit
);

  logic [IW:0] cand;

  // Walk ports ptr, ptr+1, ... wrapping at C_PORTS; first requester wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    hit       = 1'b0;
    cand      = '0;
    for (int i = 0; i < C_PORTS; i++) begin
      cand = {1'b0, ptr} + (IW+1)'(i);
      if (cand >= (IW+1)'(C_PORTS)) begin
        cand = cand - (IW+1)'(C_PORTS);
      end
      if (!hit && req[cand[IW-1:0]]) begin
        hit                   = 1'b1;
        grant[cand[IW-1:0]]   = 1'b1;
        grant_idx             = cand[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/testdrive_apb_arbiter.sv
// rtl/testdrive_apb_arbiter.sv - multi-port request arbiter driving a single APB master
module testdrive_apb_arbiter
  import testdrive_apb_arbiter_pkg::*;
#(
  parameter int C_PORTS     = 4,
  parameter int C_ADDR_BITS = 10,
  parameter int C_TIME_OUT  = 3000
) (
  input  logic                                  CLK,
  input  logic                                  nRST,
  input  logic [C_PORTS-1:0]                    REQ_VALID,
  output logic [C_PORTS-1:0]                    REQ_READY,
  input  logic [C_PORTS-1:0]                    REQ_WRITE,
  input  logic [C_PORTS-1:0][C_ADDR_BITS-1:0]   REQ_ADDR,
  input  logic [C_PORTS-1:0][APB_DATA_W-1:0]    REQ_WDATA,
  input  logic [C_PORTS-1:0][APB_STRB_W-1:0]    REQ_STRB,
  output logic [C_PORTS-1:0]                    RSP_VALID,
  output logic [APB_DATA_W-1:0]                 RSP_RDATA,
  output logic                                  RSP_ERR,
  output logic                                  PSEL,
  output logic                                  PENABLE,
  output logic                                  PWRITE,
  output logic [C_ADDR_BITS-1:0]                PADDR,
  output logic [APB_DATA_W-1:0]                 PWDATA,
  output logic [APB_STRB_W-1:0]                 PSTRB,
  input  logic [APB_DATA_W-1:0]                 PRDATA,
  input  logic                                  PREADY,
  input  logic                                  PSLVERR
);

  localparam int IW = idx_bits(C_PORTS);
  localparam int CW = (C_TIME_OUT > 0) ? $clog2(C_TIME_OUT + 1) : 1;

  apb_state_t         state;
  logic [IW-1:0]      ptr;
  logic [IW-1:0]      owner;
  logic [CW-1:0]      cnt;
  logic [C_PORTS-1:0] grant;
  logic [IW-1:0]      grant_idx;
  logic               hit;
  logic               timed_out;
  logic [IW-1:0]      next_ptr;

  testdrive_rr_arbiter #(
    .C_PORTS (C_PORTS),
    .IW      (IW)
  ) u_rr (
    .req       (REQ_VALID),
    .ptr       (ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .hit       (hit)
  );

  // Grants are only offered in IDLE and never while reset is held.
  assign REQ_READY = (nRST && (state == ST_IDLE)) ? grant : '0;

  assign next_ptr  = (grant_idx == IW'(C_PORTS - 1)) ? '0 : grant_idx + 1'b1;

  // cnt holds the 1-based index of the current ACCESS cycle.
  assign timed_out = (C_TIME_OUT > 0) && (cnt >= CW'(C_TIME_OUT));

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state     <= ST_IDLE;
      ptr       <= '0;
      owner     <= '0;
      cnt       <= '0;
      RSP_VALID <= '0;
      RSP_RDATA <= '0;
      RSP_ERR   <= 1'b0;
      PSEL      <= 1'b0;
      PENABLE   <= 1'b0;
      PWRITE    <= 1'b0;
      PADDR     <= '0;
      PWDATA    <= '0;
      PSTRB     <= '0;
    end else begin
      RSP_VALID <= '0;
      case (state)
        ST_IDLE: begin
          if (hit) begin
            state   <= ST_SETUP;
            ptr     <= next_ptr;
            owner   <= grant_idx;
            PSEL    <= 1'b1;
            PENABLE <= 1'b0;
            PWRITE  <= REQ_WRITE[grant_idx];
            PADDR   <= REQ_ADDR[grant_idx];
            PWDATA  <= REQ_WDATA[grant_idx];
            PSTRB   <= REQ_WRITE[grant_idx] ? REQ_STRB[grant_idx] : '0;
          end
        end
        ST_SETUP: begin
          state   <= ST_ACCESS;
          PENABLE <= 1'b1;
          cnt     <= CW'(1);
        end
        ST_ACCESS: begin
          // PREADY wins over a coincident timeout so a late but valid reply is kept.
          if (PREADY || timed_out) begin
            state            <= ST_IDLE;
            PSEL             <= 1'b0;
            PENABLE          <= 1'b0;
            RSP_VALID[owner] <= 1'b1;
            RSP_RDATA        <= (PREADY && !PWRITE) ? PRDATA : '0;
            RSP_ERR          <= PREADY ? PSLVERR : 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state   <= ST_IDLE;
          PSEL    <= 1'b0;
          PENABLE <= 1'b0;
        end
      endcase
    end
  end

endmodule
